div: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider that sits beside the execute stage.
- Execute drives operands and start, and holds its stall request until this block raises ready.
- It then forwards the 64-bit result into HI/LO: remainder in the upper word, quotient in the lower word.
- Supports signed (DIV) and unsigned (DIVU); annul aborts an in-flight division when a branch/flush cancels the instruction.

---
 rtl/div.sv | 221 ++++++++++++++++++++++
 tb/tb_div.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for the execute stage.
// Produces {remainder, quotient} for signed (DIV) and unsigned (DIVU)
// operands. The operation can be cancelled with annul_i. The result is held
// with ready_o high until the requester drops start_i.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [DATA_W-1:0]    rem;
  logic [DATA_W-1:0]    rem_nxt;
  logic [DATA_W-1:0]    quot;
  logic [DATA_W-1:0]    quot_nxt;
  logic [DATA_W-1:0]    divisor;
  logic [DATA_W-1:0]    divisor_nxt;
  logic                 neg_quot;
  logic                 neg_quot_nxt;
  logic                 neg_rem;
  logic                 neg_rem_nxt;
  logic [2*DATA_W-1:0]  result_nxt;
  logic                 ready_nxt;

  logic [DATA_W:0]      shifted;
  logic [DATA_W:0]      trial;
  logic                 trial_ok;
  logic                 accept;

  // Magnitude of an operand: two's complement negate only for negative signed values.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic            sgn);
    logic [DATA_W-1:0] r;
    if (sgn && v[DATA_W-1]) begin
      r = (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's complement negate used for the final sign correction.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic            neg);
    logic [DATA_W-1:0] r;
    if (neg) begin
      r = (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign accept   = start_i & ~annul_i;
  // The partial remainder is shifted in one bit wider so the trial subtract cannot overflow.
  assign shifted  = {rem, quot[DATA_W-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign trial_ok = (shifted >= {1'b0, divisor});

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FREE: begin
        if (accept) begin
          if (opdata2_i == {DATA_W{1'b0}}) begin
            state_nxt = ST_BYZERO;
          end else begin
            state_nxt = ST_ON;
          end
        end else begin
          state_nxt = ST_FREE;
        end
      end
      ST_BYZERO: begin
        state_nxt = ST_END;
      end
      ST_ON: begin
        if (annul_i) begin
          state_nxt = ST_FREE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_END;
        end else begin
          state_nxt = ST_ON;
        end
      end
      ST_END: begin
        if (start_i && !annul_i) begin
          state_nxt = ST_END;
        end else begin
          state_nxt = ST_FREE;
        end
      end
      default: begin
        state_nxt = ST_FREE;
      end
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    quot_nxt     = quot;
    divisor_nxt  = divisor;
    neg_quot_nxt = neg_quot;
    neg_rem_nxt  = neg_rem;
    result_nxt   = result_o;
    ready_nxt    = ready_o;
    case (state)
      ST_FREE: begin
        result_nxt = {(2*DATA_W){1'b0}};
        ready_nxt  = 1'b0;
        if (accept && (opdata2_i != {DATA_W{1'b0}})) begin
          cnt_nxt      = {CNT_W{1'b0}};
          rem_nxt      = {DATA_W{1'b0}};
          quot_nxt     = abs_val(opdata1_i, signed_div_i);
          divisor_nxt  = abs_val(opdata2_i, signed_div_i);
          neg_quot_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_nxt  = signed_div_i & opdata1_i[DATA_W-1];
        end else begin
          cnt_nxt = {CNT_W{1'b0}};
        end
      end
      ST_BYZERO: begin
        result_nxt = {(2*DATA_W){1'b0}};
        ready_nxt  = 1'b1;
      end
      ST_ON: begin
        if (annul_i) begin
          cnt_nxt    = {CNT_W{1'b0}};
          result_nxt = {(2*DATA_W){1'b0}};
          ready_nxt  = 1'b0;
        end else if (cnt != CNT_MAX) begin
          if (trial_ok) begin
            rem_nxt  = trial[DATA_W-1:0];
            quot_nxt = {quot[DATA_W-2:0], 1'b1};
          end else begin
            rem_nxt  = shifted[DATA_W-1:0];
            quot_nxt = {quot[DATA_W-2:0], 1'b0};
          end
          cnt_nxt    = cnt + CNT_ONE;
          result_nxt = {(2*DATA_W){1'b0}};
          ready_nxt  = 1'b0;
        end else begin
          result_nxt = {cond_neg(rem, neg_rem), cond_neg(quot, neg_quot)};
          ready_nxt  = 1'b1;
        end
      end
      ST_END: begin
        if (start_i && !annul_i) begin
          ready_nxt = 1'b1;
        end else begin
          result_nxt = {(2*DATA_W){1'b0}};
          ready_nxt  = 1'b0;
          cnt_nxt    = {CNT_W{1'b0}};
        end
      end
      default: begin
        result_nxt = {(2*DATA_W){1'b0}};
        ready_nxt  = 1'b0;
        cnt_nxt    = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath and registered outputs, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= {CNT_W{1'b0}};
      rem      <= {DATA_W{1'b0}};
      quot     <= {DATA_W{1'b0}};
      divisor  <= {DATA_W{1'b0}};
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= {(2*DATA_W){1'b0}};
      ready_o  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      rem      <= rem_nxt;
      quot     <= quot_nxt;
      divisor  <= divisor_nxt;
      neg_quot <= neg_quot_nxt;
      neg_rem  <= neg_rem_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: self-checking bench for the div block, with directed and random
// divisions checked against an arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic (truncating division), {rem, quot}; x/0 gives 0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One full transaction. Operands are scrambled after acceptance to show they are ignored.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic hold, input string name);
    logic [63:0] exp_res;
    int          exp_lat;
    int          n;
    logic        got;
    exp_res = ref_div(a, b, sgn);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
        if (!hold) start = 1'b0;
      end
      if (ready === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || (n - 1) != exp_lat)
      begin errors++; $display("FAIL %s latency: got=%0d edges (ready=%0b) expected=%0d", name, n - 1, got, exp_lat); end
    checks++;
    if (result !== exp_res)
      begin errors++; $display("FAIL %s result: got=%h expected=%h", name, result, exp_res); end
    if (hold) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || result !== exp_res)
        begin errors++; $display("FAIL %s hold: ready=%b result=%h expected ready=1 result=%h", name, ready, result, exp_res); end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL %s release: ready=%b result=%h expected ready=0 result=0", name, ready, result); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = 32'd0; opdata2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL reset: ready=%b result=%h expected ready=0 result=0", ready, result); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL idle: ready=%b result=%h expected ready=0 result=0", ready, result); end
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, 1'b1, "udiv_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "sdiv_m7_2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, "udiv_m7_2");
    run_div(32'd5, 32'd0, 1'b0, 1'b1, "div_zero");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "overflow");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, "sdiv_7_m2");
    run_div(32'd3, 32'd10, 1'b0, 1'b1, "small_dividend");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "udiv_max_max");
  endtask

  task automatic test_early_drop();
    run_div(32'hDEAD_BEEF, 32'd1234, 1'b0, 1'b0, "early_drop_u");
    run_div(32'h8765_4321, 32'hFFFF_FF00, 1'b1, 1'b0, "early_drop_s");
  endtask

  task automatic test_annul();
    logic seen;
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL annul: ready=%b result=%h expected ready=0 result=0", ready, result); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0)
      begin errors++; $display("FAIL annul_no_ready: ready seen=%b expected 0", seen); end
    run_div(32'd9, 32'd3, 1'b0, 1'b1, "after_annul");
  endtask

  task automatic test_async_reset();
    int n;
    // Reset while a result is being held must clear it without a clock edge.
    @(negedge clk);
    opdata1 = 32'd50; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (ready !== 1'b1 || result !== 64'h0000_0001_0000_0007)
      begin errors++; $display("FAIL pre_reset_end: ready=%b result=%h expected ready=1 result=0000000100000007", ready, result); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL async_reset_end: ready=%b result=%h expected ready=0 result=0", ready, result); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    // Reset mid-iteration.
    @(negedge clk);
    opdata1 = 32'h1234_5678; opdata2 = 32'd3; start = 1'b1;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0)
      begin errors++; $display("FAIL async_reset_on: ready=%b result=%h expected ready=0 result=0", ready, result); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = b & 32'h0000_00FF;
        1: b = 32'd0;
        2: a = {a[31], 31'd0} | (a & 32'h0000_FFFF);
        default: b = b;
      endcase
      run_div(a, b, s, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_div(32'd123456, 32'd789, 1'b0, 1'b1, "b2b_first");
    run_div(32'hFFFE_0000, 32'd17, 1'b1, 1'b1, "b2b_second");
    run_div(32'd0, 32'd0, 1'b1, 1'b1, "b2b_zero");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_early_drop();
    test_annul();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
